// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: shadow writeback tag layout, the
// regfile forwarding code and the stall-priority encoding.
package hazard_pkg;

  // Tag fields are sized for the largest supported configuration
  // (REG_AW up to 8, NUM_FWD up to 6); narrower addresses are zero-extended.
  localparam int TAG_RD_W  = 8;
  localparam int TAG_RDY_W = 3;

  localparam int FWD_REGFILE = 0;

  typedef logic [2:0] stall_pri_t;
  localparam stall_pri_t PRI_NONE   = 3'd0;
  localparam stall_pri_t PRI_DMISS  = 3'd1;
  localparam stall_pri_t PRI_RAW    = 3'd2;
  localparam stall_pri_t PRI_IMISS  = 3'd3;
  localparam stall_pri_t PRI_BRANCH = 3'd4;

  typedef struct packed {
    logic                 valid;
    logic [TAG_RD_W-1:0]  rd;
    logic [TAG_RDY_W-1:0] rdy_at;
  } tag_t;

  function automatic stall_pri_t pick_pri(input logic dmiss, input logic raw,
                                          input logic imiss, input logic br);
    if (dmiss)      return PRI_DMISS;
    else if (raw)   return PRI_RAW;
    else if (imiss) return PRI_IMISS;
    else if (br)    return PRI_BRANCH;
    else            return PRI_NONE;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Priority search of the shadow tag array for one ID operand: youngest
// (lowest stage) valid, non-zero match wins and reports its forwardability.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int SEL_W   = 2
) (
  input  tag_t                tags [1:NUM_FWD],
  input  logic [TAG_RD_W-1:0] operand,
  output logic                hit,
  output logic [SEL_W-1:0]    sel,
  output logic                ready
);

  logic [NUM_FWD:1] match;

  for (genvar gi = 1; gi <= NUM_FWD; gi++) begin : g_cmp
    assign match[gi] = tags[gi].valid && (tags[gi].rd != '0) && (tags[gi].rd == operand);
  end

  // Scan oldest to youngest so the youngest match overwrites the result last.
  always_comb begin
    hit   = 1'b0;
    sel   = SEL_W'(FWD_REGFILE);
    ready = 1'b0;
    for (int k = NUM_FWD; k >= 1; k--) begin
      if (match[k]) begin
        hit   = 1'b1;
        sel   = SEL_W'(k);
        ready = (k >= int'(tags[k].rdy_at));
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: shadow writeback tags, operand forwarding selects, RAW
// stall detection and stall/bubble/flush merging. HAZARD_PERF_CNT_EN adds counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int  NUM_FWD  = 3,
  parameter int  REG_AW   = 5,
  parameter int  LOAD_LAT = 1,
  parameter int  CNT_W    = 32,
  localparam int SEL_W    = $clog2(NUM_FWD + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rt,
  input  logic              id_regwrite,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_load,
  input  logic              id_br_taken,
  input  logic              icache_stall,
  input  logic              dcache_stall,
  output logic [SEL_W-1:0]  fwd_sel_x,
  output logic [SEL_W-1:0]  fwd_sel_y,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_id,
  output logic              flush_if,
  output logic              stall_back
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  cnt_raw,
  output logic [CNT_W-1:0]  cnt_dmiss,
  output logic [CNT_W-1:0]  cnt_imiss
`endif
);

  if (NUM_FWD < 2 || NUM_FWD > 6 || LOAD_LAT < 0 || LOAD_LAT >= NUM_FWD ||
      REG_AW > TAG_RD_W || CNT_W < 1) begin : g_bad_params
    $error("pipeline_hazard_ctrl: unsupported parameter set");
  end

  tag_t             tag_reg [1:NUM_FWD];
  tag_t             head_next;
  logic             hit_x, hit_y, ready_x, ready_y, raw_stall;
  logic [SEL_W-1:0] sel_x, sel_y;
  stall_pri_t       pri;

  hazard_match #(.NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_match_x (
    .tags    (tag_reg),
    .operand (TAG_RD_W'(id_rs)),
    .hit     (hit_x),
    .sel     (sel_x),
    .ready   (ready_x)
  );

  hazard_match #(.NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_match_y (
    .tags    (tag_reg),
    .operand (TAG_RD_W'(id_rt)),
    .hit     (hit_y),
    .sel     (sel_y),
    .ready   (ready_y)
  );

  // Everything is forced quiet while rst is high, even before tags are cleared.
  always_comb begin
    raw_stall  = (hit_x && !ready_x) || (id_use_rt && hit_y && !ready_y);
    pri        = pick_pri(dcache_stall, raw_stall, icache_stall, id_br_taken);
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    bubble_id  = 1'b0;
    flush_if   = 1'b0;
    stall_back = 1'b0;
    if (!rst) begin
      case (pri)
        PRI_DMISS: begin
          stall_if   = 1'b1;
          stall_id   = 1'b1;
          stall_back = 1'b1;
        end
        PRI_RAW, PRI_IMISS: begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_id = 1'b1;
        end
        PRI_BRANCH: flush_if = 1'b1;
        default: ;
      endcase
    end
    fwd_sel_x = rst ? SEL_W'(FWD_REGFILE) : sel_x;
    fwd_sel_y = (rst || !id_use_rt) ? SEL_W'(FWD_REGFILE) : sel_y;
  end

  always_comb begin
    head_next = '0;
    if (!bubble_id) begin
      head_next.valid  = id_regwrite;
      head_next.rd     = TAG_RD_W'(id_rd);
      head_next.rdy_at = id_is_load ? TAG_RDY_W'(1 + LOAD_LAT) : TAG_RDY_W'(1);
    end
  end

  // The last stage simply falls off the end: its value is in the regfile by then.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= NUM_FWD; k++) tag_reg[k] <= '0;
    end else if (!stall_back) begin
      tag_reg[1] <= head_next;
      for (int k = 2; k <= NUM_FWD; k++) tag_reg[k] <= tag_reg[k-1];
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_raw_reg, cnt_dmiss_reg, cnt_imiss_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_raw_reg   <= '0;
      cnt_dmiss_reg <= '0;
      cnt_imiss_reg <= '0;
    end else begin
      if (pri == PRI_RAW && cnt_raw_reg != '1)     cnt_raw_reg   <= cnt_raw_reg + CNT_W'(1);
      if (pri == PRI_DMISS && cnt_dmiss_reg != '1) cnt_dmiss_reg <= cnt_dmiss_reg + CNT_W'(1);
      if (pri == PRI_IMISS && cnt_imiss_reg != '1) cnt_imiss_reg <= cnt_imiss_reg + CNT_W'(1);
    end
  end

  assign cnt_raw   = cnt_raw_reg;
  assign cnt_dmiss = cnt_dmiss_reg;
  assign cnt_imiss = cnt_imiss_reg;
`endif

endmodule
